reg_lock_scoreboard: RTL and testbench

Parametrised register-lock scoreboard for the decode stage. Holds one pending-write counter per GPR and per special register (LO, HI, CP0). Decode uses it to stall on RAW hazards (rs_allow/rt_allow/spec_res) and to claim destinations when it issues. Writeback ports release the claims. It supersedes the single-bit lockreq/lockres scheme: it supports multiple outstanding writes per register, NWB writeback channels, same-cycle bypass and flush.

---
 rtl/reg_lock_scoreboard_pkg.sv | 22 ++
 rtl/reg_lock_scoreboard_lock_counter.sv | 79 +++++++
 rtl/reg_lock_scoreboard.sv | 161 ++++++++++++++++
 tb/tb_reg_lock_scoreboard.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_lock_scoreboard_pkg.sv
// Shared constants for the register-lock scoreboard.
//   - Default geometry (GPR count, index width, writeback channels, counter width).
//   - Special-register bit positions, in the same order as the old lockreq vector.
//   - rel_width(): width of a per-register release count for a given channel count.
package reg_lock_scoreboard_pkg;

  localparam int DEF_NREG  = 32;
  localparam int DEF_RW    = 5;
  localparam int DEF_NSPEC = 3;
  localparam int DEF_NWB   = 2;
  localparam int DEF_CNTW  = 2;

  localparam int SPEC_LO  = 0;
  localparam int SPEC_HI  = 1;
  localparam int SPEC_CP0 = 2;

  // Bits needed to count 0..nwb simultaneous releases of one register.
  function automatic int rel_width(input int nwb);
    return (nwb < 1) ? 1 : $clog2(nwb + 1);
  endfunction

endpackage

// File: rtl/reg_lock_scoreboard_lock_counter.sv
// lock_counter: pending-write counter for one architectural register.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   inc         : one new claim this cycle
//   rel         : number of releases this cycle
//   clr         : flush; counter goes to 0 and inc/rel are ignored
//   cnt         : registered pending count
//   eff         : count seen by decode (cnt minus same-cycle releases when bypassing)
//   full        : eff is at the maximum; one more claim would not fit
//   underflow   : this cycle's releases exceed cnt + inc (counter saturates to 0)
module lock_counter
  import reg_lock_scoreboard_pkg::*;
#(
  parameter int CNTW      = DEF_CNTW,
  parameter int RELW      = 2,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            inc,
  input  logic [RELW-1:0] rel,
  input  logic            clr,
  output logic [CNTW-1:0] cnt,
  output logic [CNTW-1:0] eff,
  output logic            full,
  output logic            underflow
);

  // Arithmetic width wide enough for cnt+inc and for rel.
  localparam int SW = ((CNTW + 1) > RELW) ? (CNTW + 1) : RELW;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [SW-1:0]   cnt_w;
  logic [SW-1:0]   rel_w;
  logic [SW-1:0]   sum;
  logic [SW-1:0]   diff;
  logic [CNTW-1:0] cnt_next;

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    cnt_w     = SW'(cnt);
    rel_w     = SW'(rel);
    sum       = cnt_w + SW'(inc);
    diff      = '0;
    underflow = 1'b0;
    cnt_next  = cnt;
    eff       = cnt;

    // A release arriving this cycle already frees the register for decode.
    if (WB_BYPASS) begin
      eff = (rel_w > cnt_w) ? '0 : CNTW'(cnt_w - rel_w);
    end

    if (clr) begin
      cnt_next = '0;
    end else if (rel_w > sum) begin
      cnt_next  = '0;
      underflow = 1'b1;
    end else begin
      diff     = sum - rel_w;
      // Cannot exceed CNT_MAX while issue_ready is honoured; clamp regardless.
      cnt_next = (diff > SW'(CNT_MAX)) ? CNT_MAX : CNTW'(diff);
    end
  end

  assign full = (eff == CNT_MAX);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its inputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/reg_lock_scoreboard.sv
// reg_lock_scoreboard: per-register pending-write tracking for decode.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   flush                : clear every lock; issue/wb inputs ignored that cycle
//   rs_addr, rt_addr     : source GPR queries
//   rs_allow, rt_allow   : source has no pending write (GPR 0 always allowed)
//   spec_req / spec_res  : special registers read / per-bit allow
//   issue_valid, issue_rd, issue_spec : destination claim from decode
//   issue_ready          : every claimed counter can take one more claim
//   wb_valid, wb_rd, wb_spec : NWB release channels
//   any_pending          : some registered counter is non-zero
//   underflow_err        : sticky, a release hit a zero counter
module reg_lock_scoreboard
  import reg_lock_scoreboard_pkg::*;
#(
  parameter int NREG      = DEF_NREG,
  parameter int RW        = DEF_RW,
  parameter int NSPEC     = DEF_NSPEC,
  parameter int NWB       = DEF_NWB,
  parameter int CNTW      = DEF_CNTW,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic [RW-1:0]      rs_addr,
  input  logic [RW-1:0]      rt_addr,
  output logic               rs_allow,
  output logic               rt_allow,
  input  logic [NSPEC-1:0]   spec_req,
  output logic [NSPEC-1:0]   spec_res,
  input  logic               issue_valid,
  input  logic [RW-1:0]      issue_rd,
  input  logic [NSPEC-1:0]   issue_spec,
  output logic               issue_ready,
  input  logic [NWB-1:0]     wb_valid,
  input  logic [NWB*RW-1:0]  wb_rd,
  input  logic [NWB*NSPEC-1:0] wb_spec,
  output logic               any_pending,
  output logic               underflow_err
);

  localparam int RELW = rel_width(NWB);

  logic                accept;

  logic [RELW-1:0]     gpr_rel  [NREG];
  logic [CNTW-1:0]     gpr_cnt  [NREG];
  logic [CNTW-1:0]     gpr_eff  [NREG];
  logic [NREG-1:0]     gpr_full;
  logic [NREG-1:0]     gpr_uf;
  logic [NREG-1:0]     gpr_busy;

  logic [RELW-1:0]     spec_rel [NSPEC];
  logic [CNTW-1:0]     spec_cnt [NSPEC];
  logic [CNTW-1:0]     spec_eff [NSPEC];
  logic [NSPEC-1:0]    spec_full;
  logic [NSPEC-1:0]    spec_uf;
  logic [NSPEC-1:0]    spec_busy;

  // Release counts per register. Gated by flush so that both the bypass view
  // and the update see the pre-flush state only.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      gpr_rel[r] = '0;
      for (int c = 0; c < NWB; c++) begin
        if (!flush && wb_valid[c] && (wb_rd[c*RW +: RW] == RW'(r))) begin
          gpr_rel[r] = gpr_rel[r] + RELW'(1);
        end
      end
    end
    for (int i = 0; i < NSPEC; i++) begin
      spec_rel[i] = '0;
      for (int c = 0; c < NWB; c++) begin
        if (!flush && wb_valid[c] && wb_spec[c*NSPEC + i]) begin
          spec_rel[i] = spec_rel[i] + RELW'(1);
        end
      end
    end
  end

  // GPR 0 is hard-wired zero: no counter, never pending, never full.
  assign gpr_cnt[0]  = '0;
  assign gpr_eff[0]  = '0;
  assign gpr_full[0] = 1'b0;
  assign gpr_uf[0]   = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_gpr
    lock_counter #(
      .CNTW      (CNTW),
      .RELW      (RELW),
      .WB_BYPASS (WB_BYPASS)
    ) u_cnt (
      .clk       (clk),
      .resetn    (resetn),
      .inc       (accept && (issue_rd == RW'(r))),
      .rel       (gpr_rel[r]),
      .clr       (flush),
      .cnt       (gpr_cnt[r]),
      .eff       (gpr_eff[r]),
      .full      (gpr_full[r]),
      .underflow (gpr_uf[r])
    );
  end

  for (genvar i = 0; i < NSPEC; i++) begin : g_spec
    lock_counter #(
      .CNTW      (CNTW),
      .RELW      (RELW),
      .WB_BYPASS (WB_BYPASS)
    ) u_cnt (
      .clk       (clk),
      .resetn    (resetn),
      .inc       (accept && issue_spec[i]),
      .rel       (spec_rel[i]),
      .clr       (flush),
      .cnt       (spec_cnt[i]),
      .eff       (spec_eff[i]),
      .full      (spec_full[i]),
      .underflow (spec_uf[i])
    );
  end

  // gpr_full[0] is 0, so issue_rd == 0 never blocks issue.
  assign issue_ready = !gpr_full[issue_rd] && !(|(issue_spec & spec_full));
  assign accept      = issue_valid && issue_ready && !flush;

  assign rs_allow = (rs_addr == '0) || (gpr_eff[rs_addr] == '0);
  assign rt_allow = (rt_addr == '0) || (gpr_eff[rt_addr] == '0);

  always_comb begin
    spec_res = '0;
    for (int i = 0; i < NSPEC; i++) begin
      spec_res[i] = !spec_req[i] || (spec_eff[i] == '0);
    end
  end

  // any_pending looks at registered counts only, never at this cycle's releases.
  always_comb begin
    gpr_busy  = '0;
    spec_busy = '0;
    for (int r = 0; r < NREG; r++) begin
      gpr_busy[r] = (gpr_cnt[r] != '0);
    end
    for (int i = 0; i < NSPEC; i++) begin
      spec_busy[i] = (spec_cnt[i] != '0);
    end
  end

  assign any_pending = (|gpr_busy) || (|spec_busy);

  // Survives flush; only reset clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      underflow_err <= 1'b0;
    end else if ((|gpr_uf) || (|spec_uf)) begin
      underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_lock_scoreboard.sv
// Self-checking bench for reg_lock_scoreboard (default parameters, bypass on).
// Table rows carry one cycle of inputs plus the hand-derived expected outputs
// for that cycle; the expectation is queued when the row is driven and popped
// when the outputs are sampled on the falling edge.
// Output bundle order: {rs_allow, rt_allow, spec_res[2:0], issue_ready,
//                       any_pending, underflow_err}.
module tb_reg_lock_scoreboard;
  import reg_lock_scoreboard_pkg::*;

  localparam int RW    = 5;
  localparam int NSPEC = 3;
  localparam int NWB   = 2;

  logic               clk;
  logic               resetn;
  logic               flush;
  logic [RW-1:0]      rs_addr;
  logic [RW-1:0]      rt_addr;
  logic               rs_allow;
  logic               rt_allow;
  logic [NSPEC-1:0]   spec_req;
  logic [NSPEC-1:0]   spec_res;
  logic               issue_valid;
  logic [RW-1:0]      issue_rd;
  logic [NSPEC-1:0]   issue_spec;
  logic               issue_ready;
  logic [NWB-1:0]     wb_valid;
  logic [NWB*RW-1:0]  wb_rd;
  logic [NWB*NSPEC-1:0] wb_spec;
  logic               any_pending;
  logic               underflow_err;

  reg_lock_scoreboard #(
    .NREG      (32),
    .RW        (RW),
    .NSPEC     (NSPEC),
    .NWB       (NWB),
    .CNTW      (2),
    .WB_BYPASS (1'b1)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .flush         (flush),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_allow      (rs_allow),
    .rt_allow      (rt_allow),
    .spec_req      (spec_req),
    .spec_res      (spec_res),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .issue_spec    (issue_spec),
    .issue_ready   (issue_ready),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_spec       (wb_spec),
    .any_pending   (any_pending),
    .underflow_err (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [2:0] sreq;
    logic       iv;
    logic [4:0] ird;
    logic [2:0] ispec;
    logic [1:0] wbv;
    logic [4:0] wrd0;
    logic [4:0] wrd1;
    logic [2:0] wsp0;
    logic [2:0] wsp1;
    logic       fl;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input string n, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [2:0] sreq, input logic iv, input logic [4:0] ird,
                              input logic [2:0] ispec, input logic [1:0] wbv,
                              input logic [4:0] wrd0, input logic [4:0] wrd1,
                              input logic [2:0] wsp0, input logic [2:0] wsp1,
                              input logic fl, input logic [7:0] e);
    vec_t v;
    v.name = n;  v.rs = rs;   v.rt = rt;     v.sreq = sreq;
    v.iv = iv;   v.ird = ird; v.ispec = ispec;
    v.wbv = wbv; v.wrd0 = wrd0; v.wrd1 = wrd1; v.wsp0 = wsp0; v.wsp1 = wsp1;
    v.fl = fl;   v.exp = e;
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {rs_allow, rt_allow, spec_res, issue_ready, any_pending, underflow_err};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    sb_t s;
    rs_addr     = v.rs;
    rt_addr     = v.rt;
    spec_req    = v.sreq;
    issue_valid = v.iv;
    issue_rd    = v.ird;
    issue_spec  = v.ispec;
    wb_valid    = v.wbv;
    wb_rd       = {v.wrd1, v.wrd0};
    wb_spec     = {v.wsp1, v.wsp0};
    flush       = v.fl;
    s.name = v.name;
    s.exp  = v.exp;
    sb_q.push_back(s);
  endtask

  task automatic sample();
    sb_t s;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: no expectation queued");
    end else begin
      s = sb_q.pop_front();
      check(s.name, outs(), s.exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    sample();
  endtask

  // Safety net: the run is far shorter than this.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    resetn      = 1'b0;
    flush       = 1'b0;
    rs_addr     = '0;
    rt_addr     = '0;
    spec_req    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    issue_spec  = '0;
    wb_valid    = '0;
    wb_rd       = '0;
    wb_spec     = '0;

    //          name             rs  rt  sreq    iv ird ispec   wbv    wrd0 wrd1 wsp0    wsp1    fl exp
    tbl.push_back(mk("reset_query",    5,  7, 3'b000, 0, 0, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b11111100));
    tbl.push_back(mk("issue_rd8",      5,  7, 3'b000, 1, 8, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b11111100));
    tbl.push_back(mk("rs8_locked",     8,  7, 3'b000, 0, 0, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b01111110));
    tbl.push_back(mk("rs8_wb_bypass",  8,  7, 3'b000, 0, 0, 3'b000, 2'b01, 8, 0, 3'b000, 3'b000, 0, 8'b11111110));
    tbl.push_back(mk("rs8_released",   8,  7, 3'b000, 0, 0, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b11111100));
    tbl.push_back(mk("issue_rd3_1",    3,  7, 3'b000, 1, 3, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b11111100));
    tbl.push_back(mk("issue_rd3_2",    3,  7, 3'b000, 1, 3, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b01111110));
    tbl.push_back(mk("issue_rd3_3",    3,  7, 3'b000, 1, 3, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b01111110));
    tbl.push_back(mk("rd3_full",       3,  7, 3'b000, 1, 3, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b01111010));
    tbl.push_back(mk("rd4_ready",      4,  3, 3'b000, 0, 4, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b10111110));
    tbl.push_back(mk("rd3_dual_rel",   3,  7, 3'b000, 0, 3, 3'b000, 2'b11, 3, 3, 3'b000, 3'b000, 0, 8'b01111110));
    tbl.push_back(mk("rd3_reissue",    3,  7, 3'b000, 1, 3, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b01111110));
    tbl.push_back(mk("rd3_rel_x2",     3,  7, 3'b000, 0, 0, 3'b000, 2'b11, 3, 3, 3'b000, 3'b000, 0, 8'b11111110));
    tbl.push_back(mk("rd3_empty",      3,  7, 3'b000, 0, 0, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b11111100));
    tbl.push_back(mk("issue_hi",       5,  7, 3'b010, 1, 0, 3'b010, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b11111100));
    tbl.push_back(mk("hi_claim_rel",   5,  7, 3'b010, 1, 0, 3'b010, 2'b10, 0, 0, 3'b000, 3'b010, 0, 8'b11111110));
    tbl.push_back(mk("hi_pending",     5,  7, 3'b010, 0, 0, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b11101110));
    tbl.push_back(mk("hi_release",     5,  7, 3'b010, 0, 0, 3'b000, 2'b01, 0, 0, 3'b010, 3'b000, 0, 8'b11111110));
    tbl.push_back(mk("uf_rd9",         9,  7, 3'b000, 0, 0, 3'b000, 2'b01, 9, 0, 3'b000, 3'b000, 0, 8'b11111100));
    tbl.push_back(mk("uf_sticky",      9,  7, 3'b000, 0, 0, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b11111101));
    tbl.push_back(mk("issue_rd0",      0,  7, 3'b000, 1, 0, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b11111101));
    tbl.push_back(mk("rd0_free",       0,  7, 3'b000, 0, 0, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b11111101));
    tbl.push_back(mk("issue_rd2",      0,  7, 3'b000, 1, 2, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b11111101));
    tbl.push_back(mk("issue_rd6",      2,  7, 3'b000, 1, 6, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b01111111));
    tbl.push_back(mk("issue_lo",       2,  6, 3'b000, 1, 0, 3'b001, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b00111111));
    tbl.push_back(mk("flush_issue10",  2,  6, 3'b001, 1, 10, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 1, 8'b00110111));
    tbl.push_back(mk("post_flush",     2, 10, 3'b001, 0, 0, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b11111101));
    tbl.push_back(mk("post_flush_rd6", 6, 10, 3'b001, 0, 0, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b11111101));

    // Reset state, observed while reset is still asserted.
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), 8'b11111100);
    @(negedge clk);
    resetn = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Asynchronous reset in the middle of operation.
    run_vec(mk("issue_rd5",   5, 7, 3'b000, 1, 5, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b11111101));
    run_vec(mk("rd5_pending", 5, 7, 3'b000, 0, 0, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b01111111));
    #1;
    resetn = 1'b0;
    #1;
    check("async_reset", outs(), 8'b11111100);
    @(negedge clk);
    resetn = 1'b1;
    run_vec(mk("after_reset_rs5", 5, 7, 3'b000, 0, 0, 3'b000, 2'b00, 0, 0, 3'b000, 3'b000, 0, 8'b11111100));

    check("scoreboard_drained", 8'(sb_q.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
